// File: rtl/clk_data_input_pkg.sv
// Shared types and constants for the clock-and-data input path.
// State encoding, edge-select codes and default lock depth.
package clk_data_input_pkg;

    typedef enum logic [1:0] {
        LOST    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;

    localparam int DEFAULT_LOCK_EDGES = 4;

endpackage

// File: rtl/cdi_edge_sync.sv
// Brings the external bit clock and symbol data into the clk domain.
// Clock gets 3 flops (edge detect), data 2 flops so d2 lines up with s2.
module cdi_edge_sync
    import clk_data_input_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       edgeSel,
    input  logic       extClk,
    input  logic [2:0] extData,
    output logic       edgeEvent,
    output logic [2:0] alignedData
);

    logic       s1;
    logic       s2;
    logic       s3;
    logic [2:0] d1;
    logic [2:0] d2;
    logic       rise;
    logic       fall;

    // Synchronizer chains for the external clock and data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
            d1 <= '0;
            d2 <= '0;
        end else begin
            s1 <= extClk;
            s2 <= s1;
            s3 <= s2;
            d1 <= extData;
            d2 <= d1;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    // Pick the edge polarity the link samples on.
    always_comb begin
        edgeEvent   = (edgeSel == EDGE_FALL) ? fall : rise;
        alignedData = d2;
    end

endmodule

// File: rtl/clk_data_input_sync.sv
// Receive-side clock/data qualifier: filters edges, tracks lock and
// measures the bit period, emitting a clock enable with aligned data.
module clk_data_input_sync
    import clk_data_input_pkg::*;
#(
    parameter int PERIOD_BITS = 16,
    parameter int LOCK_EDGES  = DEFAULT_LOCK_EDGES,
    parameter int GLITCH_BITS = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   edgeSel,
    input  logic [PERIOD_BITS-1:0] minPeriod,
    input  logic [PERIOD_BITS-1:0] timeout,
    input  logic                   clrGlitch,
    input  logic                   extClk,
    input  logic [2:0]             extData,
    output logic                   clkEnOut,
    output logic [2:0]             dataOut,
    output logic                   locked,
    output logic                   clockLost,
    output logic [PERIOD_BITS-1:0] period,
    output logic                   periodValid,
    output logic [GLITCH_BITS-1:0] glitchCount
);

    localparam int GOOD_BITS = $clog2(LOCK_EDGES + 1);

    logic                   edge_event;
    logic [2:0]             aligned_data;
    state_t                 state;
    state_t                 state_nxt;
    logic [GOOD_BITS-1:0]   good_cnt;
    logic [GOOD_BITS-1:0]   good_nxt;
    logic [PERIOD_BITS-1:0] cnt;
    logic                   in_lost;
    logic                   accept;
    logic                   reject;
    logic                   timed_out;
    logic                   last_good;
    logic                   pulse;

    cdi_edge_sync u_edge_sync (
        .clk         (clk),
        .reset       (reset),
        .edgeSel     (edgeSel),
        .extClk      (extClk),
        .extData     (extData),
        .edgeEvent   (edge_event),
        .alignedData (aligned_data)
    );

    assign in_lost   = (state == LOST);
    assign accept    = edge_event & (in_lost | (cnt >= minPeriod));
    assign reject    = edge_event & ~accept;
    assign timed_out = (timeout != '0) & (cnt >= timeout);
    assign last_good = (good_cnt == GOOD_BITS'(LOCK_EDGES - 1));

    // Lock FSM: next state, good-edge count and clock-enable pulse.
    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        pulse     = 1'b0;
        if (!enable) begin
            state_nxt = LOST;
            good_nxt  = '0;
        end else if (accept) begin
            unique case (state)
                LOST: begin
                    state_nxt = ACQUIRE;
                    good_nxt  = GOOD_BITS'(1);
                end
                ACQUIRE: begin
                    good_nxt = good_cnt + GOOD_BITS'(1);
                    if (last_good) begin
                        state_nxt = LOCKED;
                        pulse     = 1'b1;
                    end
                end
                LOCKED: begin
                    pulse = 1'b1;
                end
                default: begin
                    state_nxt = LOST;
                    good_nxt  = '0;
                end
            endcase
        end else if (timed_out) begin
            state_nxt = LOST;
            good_nxt  = '0;
        end else if (reject && state == ACQUIRE) begin
            good_nxt = '0;
        end
    end

    // FSM state and good-edge counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= LOST;
            good_cnt <= '0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
        end
    end

    // Interval counter: restarts at 1 on accepted edges, saturates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= PERIOD_BITS'(1);
        end else if (accept) begin
            cnt <= PERIOD_BITS'(1);
        end else if (~&cnt) begin
            cnt <= cnt + PERIOD_BITS'(1);
        end
    end

    // Period capture; an edge out of LOST has no valid reference.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period      <= '0;
            periodValid <= 1'b0;
        end else begin
            if (accept && !in_lost) begin
                period <= cnt;
            end
            if (state_nxt == LOST) begin
                periodValid <= 1'b0;
            end else if (accept && !in_lost) begin
                periodValid <= 1'b1;
            end
        end
    end

    // Clock-enable pulse with the symbol sampled at the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clkEnOut <= 1'b0;
            dataOut  <= '0;
        end else begin
            clkEnOut <= pulse;
            if (pulse) begin
                dataOut <= aligned_data;
            end
        end
    end

    // Saturating rejected-edge counter; clear beats a same-cycle reject.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            glitchCount <= '0;
        end else if (clrGlitch) begin
            glitchCount <= '0;
        end else if (reject && ~&glitchCount) begin
            glitchCount <= glitchCount + GLITCH_BITS'(1);
        end
    end

    assign locked    = (state == LOCKED);
    assign clockLost = (state == LOST);

endmodule

// File: tb/tb_clk_data_input_sync.sv
// Bench for clk_data_input_sync: table rows, corner sequences and a
// randomized run, all checked cycle by cycle against an edge-level model.
module tb_clk_data_input_sync;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b1;
    logic        edgeSel = 1'b0;
    logic [15:0] minPeriod = 16'd5;
    logic [15:0] timeout = 16'd100;
    logic        clrGlitch = 1'b0;
    logic        extClk = 1'b0;
    logic [2:0]  extData = 3'd0;
    logic        clkEnOut;
    logic [2:0]  dataOut;
    logic        locked;
    logic        clockLost;
    logic [15:0] period;
    logic        periodValid;
    logic [7:0]  glitchCount;

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    logic prev_en = 1'b0;

    localparam int LOCK = 4;

    // Reference model state: 0 lost, 1 acquiring, 2 locked.
    int         m_state;
    int         m_cnt;
    int         m_good;
    int         m_period;
    int         m_glitch;
    bit         m_pv;
    bit         m_clken;
    logic [2:0] m_data;
    bit         hq[$];
    logic [2:0] dq[$];

    typedef struct {
        int half;
        bit sel;
        int minp;
        int tmo;
        int halves;
        bit exp_locked;
        bit exp_lost;
        int exp_period;
        bit exp_pv;
        int exp_data;
    } vec_t;

    vec_t tbl[5];

    always #5 clk = ~clk;

    clk_data_input_sync dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .edgeSel     (edgeSel),
        .minPeriod   (minPeriod),
        .timeout     (timeout),
        .clrGlitch   (clrGlitch),
        .extClk      (extClk),
        .extData     (extData),
        .clkEnOut    (clkEnOut),
        .dataOut     (dataOut),
        .locked      (locked),
        .clockLost   (clockLost),
        .period      (period),
        .periodValid (periodValid),
        .glitchCount (glitchCount)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    // One clk cycle of the model. Inputs are stable across the posedge
    // that just passed. An extClk level sampled at posedge c shows up as
    // an edge consumed at posedge c+2; data sampled alongside it travels
    // with it.
    task automatic model_step();
        bit rise;
        bit fall;
        bit ev;
        bit acc;
        bit rej;
        logic [2:0] d;
        if (!reset) begin
            m_state  = 0;
            m_cnt    = 1;
            m_good   = 0;
            m_period = 0;
            m_pv     = 0;
            m_glitch = 0;
            m_data   = 3'd0;
            m_clken  = 0;
            hq = '{1'b0, 1'b0, 1'b0};
            dq = '{3'd0, 3'd0, 3'd0};
            return;
        end
        rise = hq[1] && !hq[2];
        fall = !hq[1] && hq[2];
        ev   = edgeSel ? fall : rise;
        d    = dq[1];
        acc  = ev && (m_state == 0 || m_cnt >= int'(minPeriod));
        rej  = ev && !acc;
        m_clken = 0;
        if (acc && m_state != 0) begin
            m_period = m_cnt;
            m_pv     = 1;
        end
        if (clrGlitch) m_glitch = 0;
        else if (rej && m_glitch < 255) m_glitch++;
        if (!enable) begin
            m_state = 0;
            m_good  = 0;
            m_pv    = 0;
        end else if (acc) begin
            if (m_state == 0) begin
                m_state = 1;
                m_good  = 1;
            end else begin
                if (m_state == 1) begin
                    m_good++;
                    if (m_good == LOCK) m_state = 2;
                end
                if (m_state == 2) begin
                    m_clken = 1;
                    m_data  = d;
                end
            end
        end else if (timeout != 0 && m_cnt >= int'(timeout)) begin
            m_state = 0;
            m_good  = 0;
            m_pv    = 0;
        end else if (rej && m_state == 1) begin
            m_good = 0;
        end
        m_cnt = acc ? 1 : (m_cnt < 65535 ? m_cnt + 1 : m_cnt);
        hq.push_front(extClk);
        void'(hq.pop_back());
        dq.push_front(extData);
        void'(dq.pop_back());
    endtask

    task automatic check_all();
        chk("clkEnOut", clkEnOut, m_clken);
        chk("dataOut", dataOut, m_data);
        chk("locked", locked, m_state == 2);
        chk("clockLost", clockLost, m_state == 0);
        chk("period", period, m_period);
        chk("periodValid", periodValid, m_pv);
        chk("glitchCount", glitchCount, m_glitch);
        chk("no_back_to_back", prev_en & clkEnOut, 0);
        prev_en = clkEnOut;
        if (clkEnOut === 1'b1) pulses++;
    endtask

    always @(negedge clk) begin
        model_step();
        check_all();
    end

    // Inputs change 1 time unit after the falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        #2;
        reset     = 1'b0;
        extClk    = 1'b0;
        extData   = 3'd0;
        clrGlitch = 1'b0;
        enable    = 1'b1;
        tick();
        tick();
        #2;
        reset = 1'b1;
        tick();
    endtask

    task automatic run_halves(input int half, input int n);
        repeat (n) begin
            extClk = ~extClk;
            if (extClk) extData = extData + 3'd1;
            repeat (half) tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int p0;
        int w;
        int hold;
        tbl[0] = '{10, 1'b0, 5, 100, 14, 1'b1, 1'b0, 20, 1'b1, 7};
        tbl[1] = '{10, 1'b1, 5, 100, 14, 1'b1, 1'b0, 20, 1'b1, 7};
        tbl[2] = '{10, 1'b0, 25, 100, 16, 1'b0, 1'b0, 40, 1'b1, 0};
        tbl[3] = '{3, 1'b0, 0, 0, 20, 1'b1, 1'b0, 6, 1'b1, 2};
        tbl[4] = '{40, 1'b0, 5, 50, 16, 1'b0, 1'b1, 0, 1'b0, 0};

        repeat (3) tick();
        chk("reset_lost", clockLost, 1);
        chk("reset_locked", locked, 0);
        chk("reset_glitch", glitchCount, 0);

        foreach (tbl[i]) begin
            do_reset();
            edgeSel   = tbl[i].sel;
            minPeriod = 16'(tbl[i].minp);
            timeout   = 16'(tbl[i].tmo);
            run_halves(tbl[i].half, tbl[i].halves);
            repeat (4) tick();
            chk($sformatf("row%0d_locked", i), locked, tbl[i].exp_locked);
            chk($sformatf("row%0d_lost", i), clockLost, tbl[i].exp_lost);
            chk($sformatf("row%0d_period", i), period, tbl[i].exp_period);
            chk($sformatf("row%0d_pv", i), periodValid, tbl[i].exp_pv);
            chk($sformatf("row%0d_data", i), dataOut, tbl[i].exp_data);
        end

        // Glitch between edges while locked.
        do_reset();
        edgeSel   = 1'b0;
        minPeriod = 16'd10;
        timeout   = 16'd100;
        run_halves(10, 10);
        p0 = pulses;
        extClk = 1'b1;
        extData = extData + 3'd1;
        repeat (6) tick();
        extClk = 1'b0;
        repeat (2) tick();
        extClk = 1'b1;
        repeat (2) tick();
        extClk = 1'b0;
        repeat (10) tick();
        extClk = 1'b1;
        extData = extData + 3'd1;
        repeat (6) tick();
        chk("glitch_count", glitchCount, 1);
        chk("glitch_pulses", pulses - p0, 2);
        chk("glitch_period", period, 20);
        chk("glitch_locked", locked, 1);

        // enable low with an edge inside the window.
        extClk = 1'b0;
        repeat (10) tick();
        enable = 1'b0;
        extClk = 1'b1;
        extData = extData + 3'd1;
        p0 = pulses;
        repeat (5) tick();
        chk("en_lost", clockLost, 1);
        chk("en_pulses", pulses - p0, 0);
        chk("en_glitch_kept", glitchCount, 1);
        enable = 1'b1;

        // Relock, then stop the clock.
        run_halves(10, 9);
        chk("relock_a", locked, 1);
        timeout = 16'd50;
        w = 0;
        while (clockLost !== 1'b1 && w < 100) begin
            tick();
            w++;
        end
        chk("timeout_lost", clockLost, 1);
        chk("timeout_locked", locked, 0);
        chk("timeout_pv", periodValid, 0);
        run_halves(10, 8);
        chk("relock_b", locked, 1);
        chk("relock_period", period, 20);

        // Glitch counter saturation and clear-vs-reject priority.
        do_reset();
        minPeriod = 16'd60000;
        timeout   = 16'd0;
        run_halves(2, 602);
        chk("sat_glitch", glitchCount, 255);
        chk("sat_not_lost", clockLost, 0);
        extClk = 1'b1;
        tick();
        tick();
        clrGlitch = 1'b1;
        tick();
        clrGlitch = 1'b0;
        chk("clr_wins", glitchCount, 0);
        extClk = 1'b0;
        repeat (2) tick();
        extClk = 1'b1;
        repeat (4) tick();
        chk("count_after_clr", glitchCount, 1);

        // Asynchronous reset in the middle of a pulse.
        do_reset();
        minPeriod = 16'd5;
        timeout   = 16'd100;
        run_halves(10, 10);
        extClk = 1'b1;
        extData = extData + 3'd1;
        repeat (3) tick();
        chk("pre_reset_pulse", clkEnOut, 1);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_clken", clkEnOut, 0);
        chk("rst_data", dataOut, 0);
        chk("rst_locked", locked, 0);
        chk("rst_lost", clockLost, 1);
        chk("rst_period", period, 0);
        chk("rst_pv", periodValid, 0);
        chk("rst_glitch", glitchCount, 0);
        extClk = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b1;

        // Randomized run against the model.
        do_reset();
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) begin
                edgeSel   = 1'($urandom_range(0, 1));
                minPeriod = 16'($urandom_range(0, 15));
                timeout   = ($urandom_range(0, 2) == 0) ? 16'd0 :
                            16'($urandom_range(30, 80));
            end
            if (hold == 0) begin
                extClk = ~extClk;
                hold = ($urandom_range(0, 9) == 0) ?
                       int'($urandom_range(40, 90)) :
                       int'($urandom_range(1, 20));
            end else begin
                hold--;
            end
            extData   = 3'($urandom);
            clrGlitch = ($urandom_range(0, 29) == 0);
            enable    = ($urandom_range(0, 99) != 0);
            tick();
        end
        enable    = 1'b1;
        clrGlitch = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
